// File: rtl/arch_reg_dump.sv
// Architectural register dump: after the core halts, walks every arch
// register through RAT then PRF and streams (idx, data) beats out.
module arch_reg_dump #(
    parameter int NUM_AREG   = 8,
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop,
    output logic [2:0]        rat_idx,
    input  logic [TAG_W-1:0]  rat_tag,
    output logic [TAG_W-1:0]  prf_addr,
    input  logic [DATA_W-1:0] prf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOOKUP,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] I_LAST      = 3'(NUM_AREG - 1);

    state_t            state_q, state_d;
    logic [2:0]        i_q, i_d;
    logic [3:0]        settle_q, settle_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [2:0]        out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    logic is_last;
    assign is_last = (i_q == I_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            settle_q   <= '0;
            tag_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            settle_q   <= settle_d;
            tag_q      <= tag_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (stop) state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_READ;
            S_READ:   state_d = S_SEND;
            S_SEND: begin
                if (out_ready) state_d = is_last ? S_DONE : S_LOOKUP;
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath registers advance alongside the state transitions above.
    always_comb begin
        i_d        = i_q;
        settle_d   = settle_q;
        tag_d      = tag_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        checksum_d = checksum_q;
        unique case (state_q)
            S_IDLE: begin
                settle_d = '0;
            end
            S_SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) i_d = '0;
            end
            S_LOOKUP: begin
                tag_d = rat_tag;
            end
            S_READ: begin
                out_data_d = prf_data;
                out_idx_d  = i_q;
            end
            S_SEND: begin
                if (out_ready) begin
                    checksum_d = checksum_q + out_data_q;
                    if (!is_last) i_d = i_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rat_idx   = (state_q == S_LOOKUP) ? i_q : '0;
        prf_addr  = (state_q == S_READ) ? tag_q : '0;
        out_valid = (state_q == S_SEND);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        out_idx   = out_idx_q;
        out_data  = out_data_q;
        checksum  = checksum_q;
    end

endmodule

// File: tb/tb_arch_reg_dump.sv
// Bench for arch_reg_dump: behavioural RAT/PRF arrays, beat order,
// timing and checksum predicted from the register map.
module tb_arch_reg_dump;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  rat_idx;
    logic [3:0]  rat_tag;
    logic [3:0]  prf_addr;
    logic [15:0] prf_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_idx;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [3:0]  rat_map [8];
    logic [15:0] prf [16];

    int checks = 0;
    int errors = 0;

    assign rat_tag  = rat_map[rat_idx];
    assign prf_data = prf[prf_addr];

    arch_reg_dump #(
        .NUM_AREG(8), .TAG_W(4), .DATA_W(16), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .stop(stop),
        .rat_idx(rat_idx), .rat_tag(rat_tag),
        .prf_addr(prf_addr), .prf_data(prf_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_idx"}, 32'(out_idx), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_csum"}, 32'(checksum), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ratidx"}, 32'(rat_idx), 0);
        chk({tag, "_prfaddr"}, 32'(prf_addr), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stop = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Streams one dump. Beat k is expected on edge SETTLE+3+3k plus every
    // stall cycle seen so far (edge 0 is the one that samples stop).
    // abort_beat >= 0 leaves the dump holding that beat in SEND.
    task automatic run_dump(input string tag, input bit rnd, input int sb,
                            input int sl, input bit pulse,
                            input int abort_beat);
        int beat = 0;
        int stalls = 0;
        int srem = sl;
        int en = 0;
        bit holding = 0;
        logic [15:0] held_d = '0;
        logic [2:0]  held_i = '0;
        logic [15:0] sum = '0;
        logic [15:0] exp_d;
        stop = 1'b1;
        tick();
        if (pulse) stop = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 1);
        for (int c = 0; c < 400 && beat < 8; c++) begin
            if (holding) begin
                chk({tag, "_hold_data"}, 32'(out_data), 32'(held_d));
                chk({tag, "_hold_idx"}, 32'(out_idx), 32'(held_i));
            end
            holding = 0;
            if (out_valid && beat == abort_beat) begin
                out_ready = 1'b0;
                return;
            end
            if (out_valid) begin
                if (rnd) out_ready = 1'($urandom_range(0, 1));
                else if (beat == sb && srem > 0) begin
                    out_ready = 1'b0;
                    srem--;
                end else out_ready = 1'b1;
                if (!out_ready) begin
                    stalls++;
                    holding = 1;
                    held_d = out_data;
                    held_i = out_idx;
                end else begin
                    exp_d = prf[rat_map[beat]];
                    chk({tag, "_idx"}, 32'(out_idx), 32'(beat));
                    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
                    chk({tag, "_edge"}, 32'(en + 1),
                        32'(SETTLE + 3 + 3 * beat + stalls));
                    sum = sum + exp_d;
                    beat++;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!pulse && !rnd && c == 2) stop = 1'b0;
            tick();
            en++;
        end
        chk({tag, "_all_beats"}, 32'(beat), 8);
        out_ready = 1'b1;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_valid_end"}, 32'(out_valid), 0);
        chk({tag, "_csum"}, 32'(checksum), 32'(sum));
        chk({tag, "_ratidx_end"}, 32'(rat_idx), 0);
        chk({tag, "_prfaddr_end"}, 32'(prf_addr), 0);
    endtask

    task automatic map_default();
        for (int i = 0; i < 8; i++) rat_map[i] = 4'(i + 8);
        for (int t = 0; t < 16; t++) prf[t] = 16'h1000 + 16'(t);
    endtask

    task automatic map_random();
        for (int i = 0; i < 8; i++) rat_map[i] = 4'($urandom_range(0, 15));
        for (int t = 0; t < 16; t++) prf[t] = 16'($urandom);
    endtask

    initial begin
        logic [15:0] csum_done;
        int vcount;
        map_default();
        do_reset();
        chk_zero_outputs("reset");
        for (int k = 0; k < 5; k++) tick();
        chk("idle_wait_busy", 32'(busy), 0);
        chk("idle_wait_valid", 32'(out_valid), 0);

        run_dump("basic", 0, -1, 0, 0, -1);

        // Stop toggling after completion must not restart anything.
        csum_done = checksum;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            stop = 1'(k & 1);
            tick();
            if (out_valid) vcount++;
        end
        chk("after_done_beats", 32'(vcount), 0);
        chk("after_done_done", 32'(done), 1);
        chk("after_done_csum", 32'(checksum), 32'(csum_done));

        do_reset();
        run_dump("stall3", 0, 3, 5, 0, -1);

        do_reset();
        for (int t = 0; t < 16; t++) prf[t] = 16'hFFFF;
        run_dump("wrap", 0, -1, 0, 0, -1);
        chk("wrap_csum_const", 32'(checksum), 32'h0000FFF8);

        map_default();
        do_reset();
        run_dump("abort", 0, -1, 0, 0, 4);
        chk("abort_in_send", 32'(out_valid), 1);
        rst = 1'b1;
        stop = 1'b1;
        tick();
        rst = 1'b0;
        stop = 1'b0;
        chk_zero_outputs("abort_rst");
        tick();
        chk("abort_idle_busy", 32'(busy), 0);
        out_ready = 1'b1;
        run_dump("after_abort", 0, -1, 0, 0, -1);

        do_reset();
        map_random();
        run_dump("pulse", 0, -1, 0, 1, -1);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            map_random();
            run_dump("rand", 1, -1, 0, 1'(r & 1), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
